// File: rtl/ring_mon_pkg.sv
// Shared definitions for the ring/Johnson counter monitor: default sizing,
// FSM state encoding and a constant log2 helper used for port widths.
package ring_mon_pkg;

  localparam int unsigned DEF_N           = 4;
  localparam int unsigned DEF_LOCK_CYCLES = 2;
  localparam int unsigned DEF_ERR_W       = 8;
  localparam int unsigned DEF_REV_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } mon_state_t;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/ring_johnson_monitor_johnson_decode.sv
// Combinational Johnson (twisted-ring) pattern decoder: maps each of the 2N
// legal codes to its phase index and flags any other pattern as illegal.
module johnson_decode
  import ring_mon_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic [N-1:0]          i_pattern,
  output logic [clog2(2*N)-1:0] o_index,
  output logic                  o_legal
);

  localparam int unsigned   IDX_W = clog2(2 * N);
  localparam logic [N-1:0]  ONES  = '1;

  logic [N-1:0] w_code;

  // Phases 0..N fill ones from the LSB; phases N+1..2N-1 then clear from the LSB.
  always_comb begin
    o_index = '0;
    o_legal = 1'b0;
    w_code  = '0;
    for (int unsigned k = 0; k < 2 * N; k++) begin
      if (k <= N) begin
        w_code = ~(ONES << k);
      end else begin
        w_code = ONES << (k - N);
      end
      if (i_pattern == w_code) begin
        o_index = IDX_W'(k);
        o_legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_johnson_monitor.sv
// Downstream checker for the ring / Johnson counter stage. Predicts each
// sample from the previous one and the observed preset/clr controls, decodes
// phases, tracks lock through a small FSM and counts faults and revolutions.
module ring_johnson_monitor
  import ring_mon_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned ERR_W       = DEF_ERR_W,
  parameter int unsigned REV_W       = DEF_REV_W
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  src_preset,
  input  logic                  src_clr,
  input  logic [N-1:0]          qr,
  input  logic [N-1:0]          qtr,
  output logic [clog2(N)-1:0]   ring_idx,
  output logic [clog2(2*N)-1:0] jc_idx,
  output logic                  idx_valid,
  output logic                  lock,
  output logic                  fault,
  output logic                  ring_dead,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [REV_W-1:0]      rev_cnt
);

  localparam int unsigned RI_W = clog2(N);
  localparam int unsigned JI_W = clog2(2 * N);
  localparam int unsigned SC_W = clog2(LOCK_CYCLES + 2);

  logic [N-1:0]     r_prev_qr;
  logic [N-1:0]     r_prev_qtr;
  logic             r_prev_preset;
  logic             r_prev_clr;
  logic             r_prev_valid;
  logic [RI_W-1:0]  r_ring_idx;
  logic [JI_W-1:0]  r_jc_idx;
  logic             r_idx_valid;
  mon_state_t       r_state;
  logic [SC_W-1:0]  r_sync_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [REV_W-1:0] r_rev_cnt;

  logic [N-1:0]     w_exp_qr;
  logic [N-1:0]     w_exp_qtr;
  logic [RI_W-1:0]  w_ring_idx;
  logic             w_ring_onehot;
  logic [JI_W-1:0]  w_jc_idx;
  logic             w_jc_legal;
  logic             w_legal;
  logic             w_match;
  logic             w_resync;
  logic             w_good;
  logic             w_jc_wrap;
  logic [SC_W-1:0]  w_sync_next;
  logic             w_sync_done;

  johnson_decode #(
    .N (N)
  ) u_jc_decode (
    .i_pattern (qtr),
    .o_index   (w_jc_idx),
    .o_legal   (w_jc_legal)
  );

  // Predict this sample from the previous one, preset taking priority over clr.
  always_comb begin
    w_exp_qr  = {r_prev_qr[N-2:0], r_prev_qr[N-1]};
    w_exp_qtr = {r_prev_qtr[N-2:0], ~r_prev_qtr[N-1]};
    if (r_prev_preset) begin
      w_exp_qr  = {r_prev_qr[N-2:0], 1'b1};
      w_exp_qtr = {r_prev_qtr[N-2:0], 1'b1};
    end else if (r_prev_clr) begin
      w_exp_qr  = '0;
      w_exp_qtr = '0;
    end
  end

  // Ring phase is the position of the single set bit.
  always_comb begin
    w_ring_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (qr[i]) w_ring_idx = RI_W'(i);
    end
  end

  assign w_ring_onehot = $onehot(qr);
  assign w_legal       = w_ring_onehot & w_jc_legal;
  assign w_match       = r_prev_valid & (qr == w_exp_qr) & (qtr == w_exp_qtr);
  assign w_resync      = r_prev_preset | r_prev_clr;
  assign w_good        = w_match & w_legal & ~w_resync;
  assign w_jc_wrap     = w_good & (w_jc_idx == '0);
  assign w_sync_next   = r_sync_cnt + 1'b1;
  assign w_sync_done   = (32'(w_sync_next) >= LOCK_CYCLES);

  // Capture previous sample/controls and register the decoded phases.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prev_qr     <= '0;
      r_prev_qtr    <= '0;
      r_prev_preset <= 1'b0;
      r_prev_clr    <= 1'b0;
      r_prev_valid  <= 1'b0;
      r_ring_idx    <= '0;
      r_jc_idx      <= '0;
      r_idx_valid   <= 1'b0;
    end else begin
      r_prev_qr     <= qr;
      r_prev_qtr    <= qtr;
      r_prev_preset <= src_preset;
      r_prev_clr    <= src_clr;
      r_prev_valid  <= 1'b1;
      r_idx_valid   <= w_legal;
      if (w_legal) begin
        r_ring_idx <= w_ring_idx;
        r_jc_idx   <= w_jc_idx;
      end
    end
  end

  // Lock FSM with saturating error count and wrapping revolution count.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_err_cnt  <= '0;
      r_rev_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_SYNC;
          r_sync_cnt <= '0;
        end
        ST_SYNC: begin
          if (w_good) begin
            if (w_sync_done) begin
              r_state    <= ST_LOCKED;
              r_sync_cnt <= '0;
            end else begin
              r_sync_cnt <= w_sync_next;
            end
          end else begin
            r_sync_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_resync) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= '0;
          end else if (!w_match || !w_legal) begin
            r_state <= ST_FAULT;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          end else if (w_jc_wrap) begin
            r_rev_cnt <= r_rev_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          if (w_resync) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= '0;
          end else if (w_good) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= SC_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_sync_cnt <= '0;
        end
      endcase
    end
  end

  assign ring_idx  = r_ring_idx;
  assign jc_idx    = r_jc_idx;
  assign idx_valid = r_idx_valid;
  assign lock      = (r_state == ST_LOCKED);
  assign fault     = (r_state == ST_FAULT);
  assign err_cnt   = r_err_cnt;
  assign rev_cnt   = r_rev_cnt;
  // Gated by prev_valid so the reset state reads all-zero outputs.
  assign ring_dead = r_prev_valid & (r_prev_qr == '0) & ~src_preset;

endmodule

// File: doc/ring_johnson_monitor.md
Name: ring_johnson_monitor

Overview:
- Downstream checker for the 4-bit ring / twisted-ring (Johnson) counter stage.
- Samples the counter's QR and QTR outputs, plus the counter's preset/clr controls, every clock.
- Decodes both counters to phase indices and flags illegal states and illegal transitions.
- Counts faults and completed Johnson revolutions; feeds the lab display/LED stage.

Parameters:
N, 4, counter width (ring has N states, Johnson has 2N).
LOCK_CYCLES, 2, consecutive good transitions needed before lock.
ERR_W, 8, width of err_cnt (saturating).
REV_W, 8, width of rev_cnt (wrapping).

Ports:
clk  in  1  single clock, all state on posedge.
clr  in  1  synchronous, active-high reset of this block.
src_preset  in  1  the counter's preset input, observed.
src_clr  in  1  the counter's clr input, observed.
qr  in  N  ring counter output.
qtr  in  N  Johnson counter output.
ring_idx  out  clog2(N)  decoded ring phase (one-hot bit position).
jc_idx  out  clog2(2N)  decoded Johnson phase.
idx_valid  out  1  both indices decoded from legal patterns this cycle.
lock  out  1  monitor is in LOCKED.
fault  out  1  monitor is in FAULT.
ring_dead  out  1  qr all-zero and no preset pending.
err_cnt  out  ERR_W  transition errors seen while LOCKED, saturating.
rev_cnt  out  REV_W  Johnson wraps (jc_idx 2N-1 -> 0) while LOCKED, modulo.

Behaviour:
- Reset (clr=1 at posedge):
  - state=IDLE; all outputs 0; prev registers 0; prev_valid=0.
  - clr has priority over every other event.
- Registered copies: prev_qr, prev_qtr, prev_preset, prev_clr; prev_valid is set on the first non-reset cycle.
- Expected value, mirroring the counter's priority (preset over clr):
  - If prev_preset: exp_qr = {prev_qr[N-2:0],1}, exp_qtr = {prev_qtr[N-2:0],1}.
  - Else if prev_clr: exp_qr = exp_qtr = 0.
  - Else: exp_qr = {prev_qr[N-2:0],prev_qr[N-1]}, exp_qtr = {prev_qtr[N-2:0],~prev_qtr[N-1]}.
- match = prev_valid & (qr==exp_qr) & (qtr==exp_qtr).
- legal = qr one-hot & qtr a legal Johnson pattern.
- Johnson decode, N=4: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7. Any other pattern is illegal.
- Ring decode: bit position of the single 1.
- Indices and idx_valid are registered, so they update one cycle after qr/qtr are sampled. When not legal, the indices hold their last value and idx_valid=0.
- good = match & legal & ~prev_preset & ~prev_clr. Preset/clr cycles are resync events, never errors.
- FSM (state transitions and outputs are registered):
  - IDLE -> SYNC after the first sample (no checking on that cycle).
  - SYNC: if good, sync_cnt++; on reaching LOCK_CYCLES -> LOCKED. Otherwise sync_cnt=0 and stay in SYNC.
  - LOCKED:
    - prev_preset or prev_clr -> SYNC with sync_cnt=0, no error.
    - ~match or ~legal -> FAULT, err_cnt++ (saturate at all-ones).
    - Jc wrap with good -> rev_cnt++.
  - FAULT: fault held at 1. good -> SYNC with sync_cnt=1. prev_preset or prev_clr -> SYNC with sync_cnt=0. Otherwise stay, and err_cnt does not increment again.
- ring_dead is combinational from the registered qr: asserted when qr==0 & ~src_preset. It is independent of the FSM.
- Simultaneous src_preset and src_clr: treated as preset, per counter priority.
- clr mid-LOCKED: immediate return to IDLE; counters cleared.

Decomposition:
- Shared package/header ring_mon_pkg holds:
  - State encodings IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2, FAULT=2'd3.
  - Default N, LOCK_CYCLES, ERR_W, REV_W.
  - A clog2 constant function.
- One natural combinational sub-module, johnson_decode: input N-bit pattern; outputs index and legal. Instantiated once for qtr.
- The ring one-hot decode stays inline.

Test Plan:
- Hold clr=1 for 2 cycles, then release with the counter in reset (qr=qtr=0000), src_preset=1 for 1 cycle, then free-run. Required: qr=0001/qtr=0001 accepted with no error; lock=1 after 2 good rotations; ring_idx steps 0,1,2,3,0; jc_idx steps 1,2,…,7,0.
- In LOCKED, run 16 clean cycles. Required: rev_cnt=2, err_cnt=0, fault=0 throughout.
- In LOCKED, force qtr 0011 -> 0101 for one cycle. Required: fault=1 and err_cnt=1 the next cycle; idx_valid=0; after the next good transition lock=0 (SYNC); lock=1 again 2 good cycles later; err_cnt stays 1.
- In LOCKED, assert src_clr for 1 cycle. Required: qr=qtr=0000 with no error; state SYNC; ring_dead=1 while qr=0000 and src_preset=0.
- Assert src_preset and src_clr together for 2 cycles. Required: expectation follows the preset shift-in-1 (0001 -> 0011); err_cnt unchanged.
- Inject 300 faults, each followed by recovery. Required: err_cnt saturates at 255. Then assert clr mid-LOCKED. Required: all outputs 0 the next cycle.
